// File: rtl/pc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_sequencer: IF-stage program counter with busy-deferred redirects   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            BUSYWAIT,
  input  logic            STALL,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            TRAP,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS_INC,
  output logic            FETCH_VALID,
  output logic            MISALIGNED
);

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            fetch_valid_nxt;
  logic            misaligned_nxt;
  logic            pending_valid, pending_valid_nxt;
  logic [XLEN-1:0] pending_target, pending_target_nxt;
  logic            pending_trap, pending_trap_nxt;
  logic            pending_mis, pending_mis_nxt;

  logic            live_redirect;
  logic            live_mis;
  logic [XLEN-1:0] live_target;

  assign live_redirect = TRAP | BRANCH_TAKEN;
  assign live_mis      = !TRAP && BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
  assign live_target   = (TRAP || live_mis) ? TRAP_VECTOR : BRANCH_TARGET;
  assign PC_PLUS_INC   = PC + INC_V;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state          <= BOOT;
      PC             <= RESET_VECTOR;
      FETCH_VALID    <= 1'b0;
      MISALIGNED     <= 1'b0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      pending_trap   <= 1'b0;
      pending_mis    <= 1'b0;
    end else begin
      state          <= state_nxt;
      PC             <= pc_nxt;
      FETCH_VALID    <= fetch_valid_nxt;
      MISALIGNED     <= misaligned_nxt;
      pending_valid  <= pending_valid_nxt;
      pending_target <= pending_target_nxt;
      pending_trap   <= pending_trap_nxt;
      pending_mis    <= pending_mis_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_nxt             = PC;
    fetch_valid_nxt    = FETCH_VALID;
    misaligned_nxt     = 1'b0;
    pending_valid_nxt  = pending_valid;
    pending_target_nxt = pending_target;
    pending_trap_nxt   = pending_trap;
    pending_mis_nxt    = pending_mis;

    case (state)
      BOOT: begin
        state_nxt       = RUN;
        fetch_valid_nxt = 1'b1;
      end
      RUN, HOLD: begin
        if (BUSYWAIT) begin
          state_nxt = HOLD;
          // A pending trap outranks any branch that shows up later in the same wait.
          if (live_redirect && !(pending_valid && pending_trap && !TRAP)) begin
            pending_valid_nxt  = 1'b1;
            pending_target_nxt = live_target;
            pending_trap_nxt   = TRAP;
            pending_mis_nxt    = live_mis;
          end
        end else begin
          state_nxt = RUN;
          if (pending_valid) begin
            pc_nxt            = pending_target;
            misaligned_nxt    = pending_mis;
            pending_valid_nxt = 1'b0;
            pending_trap_nxt  = 1'b0;
            pending_mis_nxt   = 1'b0;
          end else if (live_redirect) begin
            pc_nxt         = live_target;
            misaligned_nxt = live_mis;
          end else if (!STALL) begin
            pc_nxt = PC + INC_V;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the IF stage.
- Holds the fetch PC and advances it by a fixed increment.
- Accepts branch and trap redirects from later stages. Any redirect that arrives while instruction memory asserts BUSYWAIT is latched and applied on the first non-busy edge.
- Supplies the fetch address, PC+INC and a fetch-valid qualifier to the IF/ID pipeline register.

Parameters:
- XLEN, 32, width of PC and target buses.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on TRAP or on a misaligned branch target.
- INC, 4, sequential increment in bytes.

Ports:
- CLOCK in 1: rising-edge clock.
- RESET in 1: synchronous, active-high reset.
- BUSYWAIT in 1: instruction memory stall; PC must hold.
- STALL in 1: hazard-unit stall; PC must hold.
- BRANCH_TAKEN in 1: redirect request from EX.
- BRANCH_TARGET in XLEN: redirect address, valid with BRANCH_TAKEN.
- TRAP in 1: trap request; has priority over BRANCH_TAKEN.
- PC out XLEN: current fetch address (registered).
- PC_PLUS_INC out XLEN: PC+INC, combinational, modulo 2^XLEN.
- FETCH_VALID out 1: PC holds a fetchable address this cycle (registered).
- MISALIGNED out 1: one-cycle pulse when a branch target with [1:0]!=0 was replaced by TRAP_VECTOR.

Behaviour:
- All state updates on rising CLOCK; no other edge sensitivity and no # delays.
- Reset values (RESET high at an edge): PC=RESET_VECTOR, FETCH_VALID=0, MISALIGNED=0, pending cleared, state=BOOT. RESET overrides every other input.
- States:
  - BOOT: one cycle. Next edge with RESET low goes to RUN, sets FETCH_VALID=1, and holds PC (the first fetch is RESET_VECTOR).
  - RUN: normal operation. Goes to HOLD when BUSYWAIT=1.
  - HOLD: entered on BUSYWAIT=1. Returns to RUN on the first edge with BUSYWAIT=0.
- Effective redirect each edge, in priority order:
  1. TRAP → TRAP_VECTOR.
  2. BRANCH_TAKEN with BRANCH_TARGET[1:0]==0 → BRANCH_TARGET.
  3. BRANCH_TAKEN with BRANCH_TARGET[1:0]!=0 → TRAP_VECTOR, and MISALIGNED=1 for the next cycle.
- Misaligned checks that BRANCH_TARGET is a multiple of 4 ([1:0]==0), independent of INC.
- PC update priority in RUN with BUSYWAIT=0:
  1. Pending redirect (applied, pending cleared).
  2. Live redirect.
  3. STALL hold.
  4. PC <= PC+INC.
- A redirect overrides STALL; a stalled instruction behind a taken branch is flushed upstream.
- When BUSYWAIT=1:
  - PC holds.
  - A live redirect loads pending_valid/pending_target.
  - A later redirect during the same HOLD overwrites pending. A TRAP already pending is not overwritten by a subsequent branch.
- On leaving HOLD:
  - If pending_valid, PC <= pending_target on that edge, regardless of the live inputs.
  - Otherwise the RUN priority rules apply using the live inputs.
- Redirect latency: one edge. A request seen at edge N gives the new PC after edge N, unless deferred by BUSYWAIT.
- FETCH_VALID:
  - 0 only in BOOT and after reset.
  - Stays 1 through HOLD; BUSYWAIT qualifies fetch separately.
- Wrap-around: PC = 2^XLEN − INC increments to 0. No flag is raised.
- MISALIGNED: asserted exactly one cycle per event, then self-clears. If the misaligned redirect was deferred by BUSYWAIT, MISALIGNED pulses on the edge the redirect is applied.
- Reset mid-HOLD with a pending redirect: pending is discarded and PC=RESET_VECTOR.

Test Plan:
- Reset/boot: RESET high 2 cycles, then low. PC=0x0, FETCH_VALID 0 for one cycle then 1. Subsequent edges give PC 0x4, 0x8, 0xC.
- Stall vs branch: at PC=0x10, STALL=1 for 2 cycles → PC holds 0x10. Then STALL=1 with BRANCH_TAKEN=1, BRANCH_TARGET=0x200 → PC=0x200 next edge, then 0x204.
- Redirect under busywait: BUSYWAIT=1 at PC=0x40; BRANCH_TAKEN pulse to 0x80, then TRAP pulse, both during wait. BUSYWAIT drops → PC=0x100 (TRAP_VECTOR), then 0x104. No visit to 0x80.
- Misaligned target: BRANCH_TAKEN with target 0x0000_0302 → PC=0x100 and MISALIGNED=1 for exactly one cycle. TRAP+BRANCH_TAKEN simultaneously → PC=0x100, MISALIGNED=0.
- Wrap-around and reset mid-wait: XLEN=32, branch to 0xFFFF_FFFC → next PC 0x0000_0000. Separately, RESET asserted during HOLD with a pending redirect → PC=RESET_VECTOR, pending dropped, FETCH_VALID=0.
- Parametrised instance XLEN=16, RESET_VECTOR=0x1000, INC=2: after reset, PC 0x1000, 0x1002, 0x1004. PC_PLUS_INC at 0xFFFE is 0x0000.
